// File: rtl/cam_pkg.sv
// Shared types and combinational helpers for the CAM: FSM state, population count, priority encode.
// Helpers work on a MAX_DEPTH-wide vector; callers zero-extend and truncate to their own widths.
package cam_pkg;

  localparam int MAX_DEPTH  = 256;
  localparam int MAX_ADDR_W = 8;
  localparam int MAX_CNT_W  = 9;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } cam_state_e;

  typedef struct packed {
    logic                  hit;
    logic [MAX_ADDR_W-1:0] addr;
  } prio_t;

  function automatic logic [MAX_CNT_W-1:0] popcount(input logic [MAX_DEPTH-1:0] vec);
    logic [MAX_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      cnt = cnt + MAX_CNT_W'(vec[i]);
    end
    return cnt;
  endfunction

  // Ascending scan so the last set bit seen (highest index) wins; addr stays 0 on miss.
  function automatic prio_t prio_enc(input logic [MAX_DEPTH-1:0] vec);
    prio_t res;
    res = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (vec[i]) begin
        res.hit  = 1'b1;
        res.addr = MAX_ADDR_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cam_match_enc.sv
// Match vector to {hit, highest-index addr, match count}; purely combinational, no flow control.
// Sits in front of the response register so the lookup path stays a single cycle.
module cam_match_enc
  import cam_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0]  match_vec,
  output logic              hit,
  output logic [ADDR_W-1:0] addr,
  output logic [CNT_W-1:0]  count
);

  logic [MAX_DEPTH-1:0] vec_ext;
  prio_t                pe;

  assign vec_ext = MAX_DEPTH'(match_vec);
  assign pe      = prio_enc(vec_ext);
  assign hit     = pe.hit;
  assign addr    = ADDR_W'(pe.addr);
  assign count   = CNT_W'(popcount(vec_ext));

endmodule

// File: rtl/cam_table.sv
// Content-addressable table with valid bits, write/invalidate port, fill sequencer; lookup result 1 cycle after accept.
// Lookups are refused (lk_ready=0) and maintenance inputs ignored while the fill sequencer runs.
module cam_table
  import cam_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_start,
  input  logic              flush,
  output logic              busy,
  input  logic              wr_en,
  input  logic              inv_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              lk_req,
  output logic              lk_ready,
  input  logic [DATA_W-1:0] lk_data,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [CNT_W-1:0]  rsp_count
);

  cam_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [CNT_W-1:0]  rsp_count_q, rsp_count_d;

  logic [DEPTH-1:0]  match_vec;
  logic              enc_hit;
  logic [ADDR_W-1:0] enc_addr;
  logic [CNT_W-1:0]  enc_count;
  logic              lk_acc;

  assign busy     = (state_q == FILL);
  assign lk_ready = !busy;
  assign lk_acc   = lk_req && lk_ready;

  // Compare against registered contents, so a same-cycle write is seen only from the next lookup.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = valid_q[i] && (data_q[i] == lk_data);
    end
  end

  cam_match_enc #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_match_enc (
    .match_vec (match_vec),
    .hit       (enc_hit),
    .addr      (enc_addr),
    .count     (enc_count)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          valid_d = '0;
        end else if (fill_start) begin
          state_d = FILL;
          ptr_d   = '0;
        end else begin
          // Loop compare also drops writes aimed past DEPTH-1.
          for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr == ADDR_W'(i)) begin
              if (inv_en) begin
                valid_d[i] = 1'b0;
              end else if (wr_en) begin
                data_d[i]  = wr_data;
                valid_d[i] = 1'b1;
              end
            end
          end
        end
      end
      FILL: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ptr_q == ADDR_W'(i)) begin
            data_d[i]  = DATA_W'(i);
            valid_d[i] = 1'b1;
          end
        end
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid_d = lk_acc;
    rsp_hit_d   = rsp_hit_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_count_d = rsp_count_q;
    if (lk_acc) begin
      rsp_hit_d   = enc_hit;
      rsp_addr_d  = enc_addr;
      rsp_count_d = enc_count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      valid_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      valid_q     <= valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_count_q <= rsp_count_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_count = rsp_count_q;

endmodule

// File: tb/tb_cam_table.sv
// Directed bench for cam_table (DEPTH=8, DATA_W=16): reset, fill, priority/count, hazards, flush, reset mid-fill.
module tb_cam_table;

  logic        clk;
  logic        rst_n;
  logic        fill_start;
  logic        flush;
  logic        busy;
  logic        wr_en;
  logic        inv_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        lk_req;
  logic        lk_ready;
  logic [15:0] lk_data;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [2:0]  rsp_addr;
  logic [3:0]  rsp_count;

  int n_cmp  = 0;
  int n_fail = 0;

  cam_table #(
    .DATA_W (16),
    .DEPTH  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fill_start (fill_start),
    .flush      (flush),
    .busy       (busy),
    .wr_en      (wr_en),
    .inv_en     (inv_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .lk_req     (lk_req),
    .lk_ready   (lk_ready),
    .lk_data    (lk_data),
    .rsp_valid  (rsp_valid),
    .rsp_hit    (rsp_hit),
    .rsp_addr   (rsp_addr),
    .rsp_count  (rsp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Result packed as {valid, hit, addr[2:0], count[3:0]}.
  task automatic do_lookup(input logic [15:0] k, output logic [8:0] r);
    lk_req  = 1'b1;
    lk_data = k;
    tick();
    lk_req  = 1'b0;
    r = {rsp_valid, rsp_hit, rsp_addr, rsp_count};
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    logic [8:0] r;
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({busy, lk_ready, rsp_valid, rsp_hit, rsp_addr, rsp_count} !== 11'b010_0000_0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b",
               {busy, lk_ready, rsp_valid, rsp_hit, rsp_addr, rsp_count}, 11'b010_0000_0000);
    end
    rst_n = 1'b1;
    tick();
    do_lookup(16'h0000, r);
    n_cmp++;
    if (r !== {1'b1, 1'b0, 3'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_lookup0: got %b expected %b", r, {1'b1, 1'b0, 3'd0, 4'd0});
    end
  endtask

  task automatic test_fill();
    logic [8:0] r;
    int n;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    lk_req     = 1'b1;
    lk_data    = 16'h0000;
    n = 0;
    while (busy && n < 40) begin
      n++;
      n_cmp++;
      if ({lk_ready, rsp_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL fill_lookup_blocked: got ready,valid=%b expected 00", {lk_ready, rsp_valid});
      end
      tick();
    end
    lk_req = 1'b0;
    n_cmp++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL fill_busy_cycles: got %0d expected 8", n);
    end
    do_lookup(16'h0005, r);
    n_cmp++;
    if (r !== {1'b1, 1'b1, 3'd5, 4'd1}) begin
      n_fail++;
      $display("FAIL fill_lookup5: got %b expected %b", r, {1'b1, 1'b1, 3'd5, 4'd1});
    end
    tick();
    n_cmp++;
    if ({rsp_valid, rsp_hit, rsp_addr, rsp_count} !== {1'b0, 1'b1, 3'd5, 4'd1}) begin
      n_fail++;
      $display("FAIL rsp_hold: got %b expected %b",
               {rsp_valid, rsp_hit, rsp_addr, rsp_count}, {1'b0, 1'b1, 3'd5, 4'd1});
    end
    do_lookup(16'h0009, r);
    n_cmp++;
    if (r !== {1'b1, 1'b0, 3'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL fill_lookup9: got %b expected %b", r, {1'b1, 1'b0, 3'd0, 4'd0});
    end
  endtask

  task automatic test_dup_inv();
    logic [8:0] r;
    do_write(3'd2, 16'h00AB);
    do_write(3'd6, 16'h00AB);
    do_lookup(16'h00AB, r);
    n_cmp++;
    if (r !== {1'b1, 1'b1, 3'd6, 4'd2}) begin
      n_fail++;
      $display("FAIL dup_lookup: got %b expected %b", r, {1'b1, 1'b1, 3'd6, 4'd2});
    end
    inv_en  = 1'b1;
    wr_addr = 3'd6;
    tick();
    inv_en  = 1'b0;
    do_lookup(16'h00AB, r);
    n_cmp++;
    if (r !== {1'b1, 1'b1, 3'd2, 4'd1}) begin
      n_fail++;
      $display("FAIL inv_lookup: got %b expected %b", r, {1'b1, 1'b1, 3'd2, 4'd1});
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] r;
    wr_en   = 1'b1;
    wr_addr = 3'd3;
    wr_data = 16'h1234;
    lk_req  = 1'b1;
    lk_data = 16'h1234;
    tick();
    wr_en   = 1'b0;
    r = {rsp_valid, rsp_hit, rsp_addr, rsp_count};
    n_cmp++;
    if (r !== {1'b1, 1'b0, 3'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL same_cycle_wr_lk: got %b expected %b", r, {1'b1, 1'b0, 3'd0, 4'd0});
    end
    tick();
    r = {rsp_valid, rsp_hit, rsp_addr, rsp_count};
    n_cmp++;
    if (r !== {1'b1, 1'b1, 3'd3, 4'd1}) begin
      n_fail++;
      $display("FAIL next_cycle_lk: got %b expected %b", r, {1'b1, 1'b1, 3'd3, 4'd1});
    end
    lk_data = 16'h0003;
    tick();
    lk_req  = 1'b0;
    r = {rsp_valid, rsp_hit, rsp_addr, rsp_count};
    n_cmp++;
    if (r !== {1'b1, 1'b0, 3'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL overwritten_key: got %b expected %b", r, {1'b1, 1'b0, 3'd0, 4'd0});
    end
  endtask

  task automatic test_priority();
    logic [8:0] r;
    int n;
    inv_en  = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 3'd2;
    wr_data = 16'h0055;
    tick();
    inv_en  = 1'b0;
    wr_en   = 1'b0;
    do_lookup(16'h0055, r);
    n_cmp++;
    if (r !== {1'b1, 1'b0, 3'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL inv_wr_newkey: got %b expected %b", r, {1'b1, 1'b0, 3'd0, 4'd0});
    end
    do_lookup(16'h00AB, r);
    n_cmp++;
    if (r !== {1'b1, 1'b0, 3'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL inv_wr_oldkey: got %b expected %b", r, {1'b1, 1'b0, 3'd0, 4'd0});
    end
    fill_start = 1'b1;
    flush      = 1'b1;
    tick();
    fill_start = 1'b0;
    flush      = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_beats_fill: got busy=%b expected 0", busy);
    end
    do_lookup(16'h0001, r);
    n_cmp++;
    if (r !== {1'b1, 1'b0, 3'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL flush_cleared: got %b expected %b", r, {1'b1, 1'b0, 3'd0, 4'd0});
    end
    fill_start = 1'b1;
    wr_en      = 1'b1;
    wr_addr    = 3'd0;
    wr_data    = 16'h0077;
    tick();
    fill_start = 1'b0;
    wr_en      = 1'b0;
    wait_idle(n);
    n_cmp++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL fill_with_wr_cycles: got %0d expected 8", n);
    end
    do_lookup(16'h0077, r);
    n_cmp++;
    if (r !== {1'b1, 1'b0, 3'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL fill_drops_wr: got %b expected %b", r, {1'b1, 1'b0, 3'd0, 4'd0});
    end
    do_lookup(16'h0000, r);
    n_cmp++;
    if (r !== {1'b1, 1'b1, 3'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL fill_entry0: got %b expected %b", r, {1'b1, 1'b1, 3'd0, 4'd1});
    end
  endtask

  task automatic test_full_and_flush();
    logic [8:0] r;
    for (int i = 0; i < 8; i++) begin
      do_write(3'(i), 16'hFFFF);
    end
    do_lookup(16'hFFFF, r);
    n_cmp++;
    if (r !== {1'b1, 1'b1, 3'd7, 4'd8}) begin
      n_fail++;
      $display("FAIL all_match_count: got %b expected %b", r, {1'b1, 1'b1, 3'd7, 4'd8});
    end
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 3'd1;
    wr_data = 16'hFFFF;
    tick();
    flush   = 1'b0;
    wr_en   = 1'b0;
    do_lookup(16'hFFFF, r);
    n_cmp++;
    if (r !== {1'b1, 1'b0, 3'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL flush_with_wr: got %b expected %b", r, {1'b1, 1'b0, 3'd0, 4'd0});
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [8:0] r;
    int n;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, rsp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset_mid_fill: got busy,valid=%b expected 00", {busy, rsp_valid});
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_not_resumed: got busy=%b expected 0", busy);
    end
    for (int k = 0; k < 8; k++) begin
      do_lookup(16'(k), r);
      n_cmp++;
      if (r !== {1'b1, 1'b0, 3'd0, 4'd0}) begin
        n_fail++;
        $display("FAIL post_reset_miss_%0d: got %b expected %b", k, r, {1'b1, 1'b0, 3'd0, 4'd0});
      end
    end
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    wait_idle(n);
    n_cmp++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL refill_cycles: got %0d expected 8", n);
    end
    do_lookup(16'h0007, r);
    n_cmp++;
    if (r !== {1'b1, 1'b1, 3'd7, 4'd1}) begin
      n_fail++;
      $display("FAIL refill_lookup7: got %b expected %b", r, {1'b1, 1'b1, 3'd7, 4'd1});
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    fill_start = 1'b0;
    flush      = 1'b0;
    wr_en      = 1'b0;
    inv_en     = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    lk_req     = 1'b0;
    lk_data    = '0;
    test_reset();
    test_fill();
    test_dup_inv();
    test_back_to_back();
    test_priority();
    test_full_and_flush();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
